wptr_full_ctrl: RTL and testbench

//  Write-side pointer/flag controller of the dual-clock FIFO, the counterpart of the read-side empty logic.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/gray2bin_conv.sv | 21 ++
 rtl/wptr_full_ctrl.sv | 111 +++++++++++
 tb/tb_wptr_full_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the write- and read-side pointer/flag controllers.
// Contents:
//   ADDRSIZE_DEFAULT  default RAM address width (depth = 2**ADDRSIZE)
//   wstat_t           packed status word {full, afull, ovf}
//   bin2gray          binary-to-Gray conversion on a 32-bit container; callers slice the result
package fifo_pkg;

    localparam int unsigned ADDRSIZE_DEFAULT = 8;

    typedef struct packed {
        logic full;
        logic afull;
        logic ovf;
    } wstat_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of the Gray bits at and above its position.
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent
module gray2bin_conv #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            // Shift keeps bit i..MSB, zero-fills above, so the reduction is the prefix XOR.
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller of the dual-clock FIFO (wclk domain only).
// Holds the binary write counter and Gray write pointer, drives the RAM write address and
// produces registered full, almost-full, fill level and sticky overflow flags from the
// already-synchronized Gray read pointer.
// Build option: macro WPTR_FULL_LEVEL_EN builds the level/almost-full path; without it
// wlevel and wafull are held at 0 and everything else is unchanged.
// Ports:
//   wclk      in   1           write clock, rising edge
//   wrst_n    in   1           synchronous active-low reset
//   winc      in   1           write request
//   wq2_rptr  in   ADDRSIZE+1  Gray read pointer synchronized into wclk
//   wovf_clr  in   1           clears the sticky overflow flag
//   waddr     out  ADDRSIZE    RAM write address
//   wptr      out  ADDRSIZE+1  registered Gray write pointer
//   wfull     out  1           registered full flag
//   wafull    out  1           registered almost-full flag
//   wlevel    out  ADDRSIZE+1  registered fill level (pessimistic)
//   wovf      out  1           sticky overflow flag
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = ADDRSIZE_DEFAULT,
    parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [31:0]       gray_wide;
    logic              accept;
    wstat_t            stat_q;
    wstat_t            stat_d;

    assign accept    = winc & ~stat_q.full;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, accept};
    assign gray_wide = bin2gray(32'(wbinnext));
    assign wgraynext = gray_wide[ADDRSIZE:0];

`ifdef WPTR_FULL_LEVEL_EN
    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next;
    logic [ADDRSIZE:0] level_q;

    gray2bin_conv #(
        .WIDTH (ADDRSIZE + 1)
    ) u_gray2bin_conv (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Modulo subtraction; the counter MSB makes a full FIFO read as 2**ADDRSIZE.
    assign level_next = wbinnext - rbin_s;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_next;
        end
    end

    assign wlevel = level_q;
`else
    assign wlevel = '0;
`endif

    always_comb begin
        stat_d      = '0;
        // Full when the next pointer equals the read pointer with its two MSBs inverted.
        stat_d.full = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
`ifdef WPTR_FULL_LEVEL_EN
        stat_d.afull = (level_next >= AFULL_LVL);
`else
        stat_d.afull = 1'b0;
`endif
        // Set beats clear when both happen in the same cycle.
        stat_d.ovf = (winc & stat_q.full) | (stat_q.ovf & ~wovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            stat_q <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            stat_q <= stat_d;
        end
    end

    assign waddr  = wbin[ADDRSIZE-1:0];
    assign wfull  = stat_q.full;
    assign wafull = stat_q.afull;
    assign wovf   = stat_q.ovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl with ADDRSIZE=4, AFULL_THRESH=14.
// A small behavioural model tracks the expected state; key points are also checked
// against hand-computed constants. Works with or without WPTR_FULL_LEVEL_EN.
module tb_wptr_full_ctrl;

    localparam int unsigned AW = 4;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [AW:0]   wq2_rptr;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          wovf;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [AW:0] m_bin;
    logic        m_full;
    logic        m_ovf;
    logic [AW:0] m_level;
    logic        m_afull;

    wptr_full_ctrl #(
        .ADDRSIZE     (AW),
        .AFULL_THRESH (14)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .wovf_clr (wovf_clr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] to_bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [AW:0] exp_level();
`ifdef WPTR_FULL_LEVEL_EN
        return m_level;
`else
        return '0;
`endif
    endfunction

    function automatic logic exp_afull();
`ifdef WPTR_FULL_LEVEL_EN
        return m_afull;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model with the inputs present before the coming edge.
    task automatic model_step();
        logic        acc;
        logic [AW:0] nb;
        logic        ovf_n;
        if (!wrst_n) begin
            m_bin = '0; m_full = 0; m_ovf = 0; m_level = '0; m_afull = 0;
        end else begin
            acc     = winc & ~m_full;
            nb      = m_bin + {4'b0, acc};
            ovf_n   = (winc & m_full) | (m_ovf & ~wovf_clr);
            m_level = nb - to_bin(wq2_rptr);
            m_full  = (m_level == 5'd16);
            m_afull = (m_level >= 5'd14);
            m_ovf   = ovf_n;
            m_bin   = nb;
        end
    endtask

    // One clock: model, edge, sample 1 time unit later, compare everything.
    task automatic cycle(input string tag);
        model_step();
        @(posedge wclk);
        #1;
        check_eq({tag, "_waddr"}, 32'(waddr), 32'(m_bin[AW-1:0]));
        check_eq({tag, "_wptr"}, 32'(wptr), 32'(to_gray(m_bin)));
        check_eq({tag, "_wfull"}, 32'(wfull), 32'(m_full));
        check_eq({tag, "_wovf"}, 32'(wovf), 32'(m_ovf));
        check_eq({tag, "_wlevel"}, 32'(wlevel), 32'(exp_level()));
        check_eq({tag, "_wafull"}, 32'(wafull), 32'(exp_afull()));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_zero"}, {21'd0, waddr, wptr, wfull, wafull, wovf}, 32'd0);
        check_eq({tag, "_zlevel"}, 32'(wlevel), 32'd0);
    endtask

    initial begin
        logic [AW:0] prev_ptr;
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wq2_rptr = '0;
        wovf_clr = 1'b0;
        m_bin = '0; m_full = 0; m_ovf = 0; m_level = '0; m_afull = 0;

        // 1: reset with winc asserted, then release idle
        cycle("rst0");
        cycle("rst1");
        check_all_zero("rst");
        wrst_n = 1'b1;
        winc   = 1'b0;
        cycle("rel");
        check_all_zero("rel");

        // 2: fill 16 entries
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            prev_ptr = wptr;
            cycle("fill");
            check_eq("fill_gray1", $countones(wptr ^ prev_ptr), 1);
            check_eq("fill_waddr", 32'(waddr), 32'(i % 16));
            if (i == 13) check_eq("afull_13", 32'(wafull), 32'd0);
            if (i == 14) check_eq("afull_14", 32'(wafull), 32'(exp_afull()));
            if (i == 15) check_eq("full_15", 32'(wfull), 32'd0);
        end
        check_eq("full_16", 32'(wfull), 32'd1);
        check_eq("ptr_16", 32'(wptr), 32'h18);
`ifdef WPTR_FULL_LEVEL_EN
        check_eq("level_16", 32'(wlevel), 32'd16);
`endif

        // 3: overflow
        cycle("ovf");
        check_eq("ovf_set", 32'(wovf), 32'd1);
        check_eq("ovf_ptr", 32'(wptr), 32'h18);
        wovf_clr = 1'b1;
        cycle("ovf_setclr");
        check_eq("ovf_setwins", 32'(wovf), 32'd1);
        winc = 1'b0;
        cycle("ovf_clr");
        check_eq("ovf_cleared", 32'(wovf), 32'd0);
        wovf_clr = 1'b0;

        // 4: reader frees three slots
        wq2_rptr = to_gray(5'd3);
        cycle("drain");
        check_eq("drain_full", 32'(wfull), 32'd0);
        check_eq("drain_afull", 32'(wafull), 32'd0);
`ifdef WPTR_FULL_LEVEL_EN
        check_eq("drain_level", 32'(wlevel), 32'd13);
`endif

        // 5: wrap with read pointer lagging
        wrst_n = 1'b0;
        wq2_rptr = '0;
        cycle("rst2");
        wrst_n = 1'b1;
        winc   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wq2_rptr = (i < 2) ? 5'd0 : to_gray(m_bin - 5'd1);
            cycle("wrap");
            check_eq("wrap_nofull", 32'(wfull), 32'd0);
`ifdef WPTR_FULL_LEVEL_EN
            if (i >= 1) check_eq("wrap_level", 32'(wlevel), 32'd2);
`endif
        end
        check_eq("wrap_addr", 32'(waddr), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
